// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and sizes for the ID-stage hazard scoreboard.
package id_hazard_scoreboard_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned NumRegs  = 32;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFault = 2'd2
  } hz_state_e;

endpackage

// File: rtl/id_hazard_scoreboard_sb_counter_bank.sv
// Per-register in-flight write counters with zero / one / full flags.
module sb_counter_bank
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CntW = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_en_i,
  input  logic [RegAddrW-1:0] inc_addr_i,
  input  logic                dec_en_i,
  input  logic [RegAddrW-1:0] dec_addr_i,
  output logic [NumRegs-1:0]  zero_o,
  output logic [NumRegs-1:0]  one_o,
  output logic [NumRegs-1:0]  full_o
);

  localparam logic [CntW-1:0] CntMax = '1;

  for (genvar g = 0; g < NumRegs; g++) begin : g_cnt
    logic            inc, dec;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Register 0 is hardwired and never counted; decrements of an idle entry are dropped.
    assign inc = inc_en_i && (inc_addr_i == RegAddrW'(g)) && (g != 0) && (cnt_q != CntMax);
    assign dec = dec_en_i && (dec_addr_i == RegAddrW'(g)) && (g != 0) && (cnt_q != '0);

    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign zero_o[g] = (cnt_q == '0);
    assign one_o[g]  = (cnt_q == CntW'(1));
    assign full_o[g] = (cnt_q == CntMax);
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: stall/issue/flush decision, stall watchdog.
// Optional HAZARD_STATS_EN adds saturating stall-cycle and flush counters.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned CntW     = 2,
  parameter int unsigned MaxStall = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_valid_i,
  input  logic [RegAddrW-1:0] id_rs_i,
  input  logic [RegAddrW-1:0] id_rt_i,
  input  logic                id_uses_rs_i,
  input  logic                id_uses_rt_i,
  input  logic [RegAddrW-1:0] id_dest_i,
  input  logic                id_writes_i,
  input  logic                ex_redirect_i,
  input  logic                wb_valid_i,
  input  logic [RegAddrW-1:0] wb_dest_i,
  output logic                id_issue_o,
  output logic                id_stall_o,
  output logic                id_flush_o,
`ifdef HAZARD_STATS_EN
  output logic [31:0]         stat_stall_cycles_o,
  output logic [15:0]         stat_flushes_o,
`endif
  output logic                sb_busy_o,
  output logic                stall_fault_o
);

  localparam int unsigned       StallW    = $clog2(MaxStall + 1);
  localparam logic [StallW-1:0] StallLast = StallW'(MaxStall);

  logic [NumRegs-1:0] cnt_zero, cnt_one, cnt_full;
  logic               rs_pend, rt_pend, rs_byp, rt_byp, raw, sat, hazard, in_fault;
  logic               issue, stall, flush;
  hz_state_e          state_q, state_d;
  logic [StallW-1:0]  stall_cnt_q, stall_cnt_d;

  sb_counter_bank #(
    .CntW(CntW)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_en_i  (issue && id_writes_i),
    .inc_addr_i(id_dest_i),
    .dec_en_i  (wb_valid_i),
    .dec_addr_i(wb_dest_i),
    .zero_o    (cnt_zero),
    .one_o     (cnt_one),
    .full_o    (cnt_full)
  );

  // A WB retiring the last pending write of a source forwards it this cycle.
  assign rs_pend = id_uses_rs_i && (id_rs_i != '0) && !cnt_zero[id_rs_i];
  assign rt_pend = id_uses_rt_i && (id_rt_i != '0) && !cnt_zero[id_rt_i];
  assign rs_byp  = wb_valid_i && (wb_dest_i == id_rs_i) && cnt_one[id_rs_i];
  assign rt_byp  = wb_valid_i && (wb_dest_i == id_rt_i) && cnt_one[id_rt_i];
  assign raw     = (rs_pend && !rs_byp) || (rt_pend && !rt_byp);
  assign sat     = id_writes_i && (id_dest_i != '0) && cnt_full[id_dest_i];
  assign hazard  = raw || sat;

  assign in_fault = (state_q == StFault);
  assign flush    = id_valid_i && ex_redirect_i;
  assign stall    = id_valid_i && !ex_redirect_i && hazard && !in_fault;
  assign issue    = id_valid_i && !ex_redirect_i && !hazard && !in_fault;

  // Outputs are forced low while reset is held, independent of the ID inputs.
  assign id_flush_o    = rst_ni && flush;
  assign id_stall_o    = rst_ni && stall;
  assign id_issue_o    = rst_ni && issue;
  assign sb_busy_o     = ~&cnt_zero;
  assign stall_fault_o = in_fault;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      StRun: begin
        if (stall) state_d = StStall;
      end
      StStall: begin
        if (!stall) begin
          state_d     = StRun;
          stall_cnt_d = '0;
        end else begin
          if (stall_cnt_q != StallLast) stall_cnt_d = stall_cnt_q + 1'b1;
          if (stall_cnt_d == StallLast) state_d = StFault;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d     = StRun;
        stall_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_q;
  logic [15:0] stat_flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_stall_q <= '0;
      stat_flush_q <= '0;
    end else begin
      if (stall && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 1'b1;
      if (flush && (stat_flush_q != '1)) stat_flush_q <= stat_flush_q + 1'b1;
    end
  end

  assign stat_stall_cycles_o = stat_stall_q;
  assign stat_flushes_o      = stat_flush_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a counting model.
module tb_id_hazard_scoreboard;

  localparam int MaxStall = 15;
  localparam int CntMax   = 3;

  logic       clk, rst_n;
  logic       id_valid, id_uses_rs, id_uses_rt, id_writes, ex_redirect, wb_valid;
  logic [4:0] id_rs, id_rt, id_dest, wb_dest;
  logic       id_issue, id_stall, id_flush, sb_busy, stall_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending writes per register, consecutive stalled cycles, sticky fault.
  int m_cnt[32];
  int m_run;
  bit m_fault;

  bit obs_issue, obs_stall, obs_flush, obs_busy, obs_fault;

  id_hazard_scoreboard dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rs_i (id_uses_rs),
    .id_uses_rt_i (id_uses_rt),
    .id_dest_i    (id_dest),
    .id_writes_i  (id_writes),
    .ex_redirect_i(ex_redirect),
    .wb_valid_i   (wb_valid),
    .wb_dest_i    (wb_dest),
    .id_issue_o   (id_issue),
    .id_stall_o   (id_stall),
    .id_flush_o   (id_flush),
    .sb_busy_o    (sb_busy),
    .stall_fault_o(stall_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] rs, input logic [4:0] rt, input bit urs,
                       input bit urt, input logic [4:0] d, input bit w, input bit red,
                       input bit wbv, input logic [4:0] wbd);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = d; id_writes = w; ex_redirect = red; wb_valid = wbv; wb_dest = wbd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic bit model_busy();
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: inputs already driven just after the edge; check mid-cycle, then advance model.
  task automatic step();
    bit raw_rs, raw_rt, sat, haz, e_flush, e_stall, e_issue;
    int inc, dec;
    #4;
    raw_rs  = id_uses_rs && id_rs != 0 && m_cnt[id_rs] != 0 &&
              !(wb_valid && wb_dest == id_rs && m_cnt[id_rs] == 1);
    raw_rt  = id_uses_rt && id_rt != 0 && m_cnt[id_rt] != 0 &&
              !(wb_valid && wb_dest == id_rt && m_cnt[id_rt] == 1);
    sat     = id_writes && id_dest != 0 && m_cnt[id_dest] == CntMax;
    haz     = raw_rs || raw_rt || sat;
    e_flush = id_valid && ex_redirect;
    e_stall = id_valid && !ex_redirect && haz && !m_fault;
    e_issue = id_valid && !ex_redirect && !haz && !m_fault;
    obs_issue = id_issue; obs_stall = id_stall; obs_flush = id_flush;
    obs_busy  = sb_busy;  obs_fault = stall_fault;
    check("id_issue", 32'(id_issue), 32'(e_issue));
    check("id_stall", 32'(id_stall), 32'(e_stall));
    check("id_flush", 32'(id_flush), 32'(e_flush));
    check("sb_busy", 32'(sb_busy), 32'(model_busy()));
    check("stall_fault", 32'(stall_fault), 32'(m_fault));
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      inc = (e_issue && id_writes && id_dest == r) ? 1 : 0;
      dec = (wb_valid && wb_dest == r && m_cnt[r] > 0) ? 1 : 0;
      m_cnt[r] = m_cnt[r] + inc - dec;
    end
    // Fault after the entry stall plus MaxStall further stalled cycles.
    if (e_stall) m_run++; else m_run = 0;
    if (m_run > MaxStall) m_fault = 1'b1;
    #1;
  endtask

  // Assert reset in the drive phase; outputs must drop before any clock edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_issue", 32'(id_issue), 0);
    check("rst_stall", 32'(id_stall), 0);
    check("rst_flush", 32'(id_flush), 0);
    check("rst_busy", 32'(sb_busy), 0);
    check("rst_fault", 32'(stall_fault), 0);
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_run = 0;
    m_fault = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int stalls_seen;
    bit fault_seen;
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply_reset();

    // 1: RAW on $3, then WB bypass releases it the same cycle.
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0); step();
    check("t1_stall", 32'(obs_stall), 1);
    drive(1, 3, 0, 1, 0, 0, 0, 0, 1, 3); step();
    check("t1_bypass_issue", 32'(obs_issue), 1);

    // 2: three writers of $5 saturate; fourth issues the cycle after one WB.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    end
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    check("t2_sat_stall", 32'(obs_stall), 1);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 5); step();
    check("t2_sat_wb_cycle", 32'(obs_stall), 1);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); step();
    check("t2_sat_issue", 32'(obs_issue), 1);

    // 3: redirect beats a pending stall.
    drive(1, 5, 5, 1, 1, 6, 1, 1, 0, 0); step();
    check("t3_flush", 32'(obs_flush), 1);
    check("t3_no_stall", 32'(obs_stall), 0);

    // Drain $5 so the $0 test starts with an empty scoreboard.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5); step();
    end

    // 4: $0 traffic never stalls or counts.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 1, 1, 0, 1, 0, 0, 0); step();
      check("t4_zero_busy", 32'(obs_busy), 0);
    end

    // Random traffic over a narrow register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(9, 0) < 8, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
            1'($urandom), 1'($urandom), 5'($urandom_range(7, 0)),
            $urandom_range(9, 0) < 6, $urandom_range(9, 0) == 0,
            1'($urandom), 5'($urandom_range(7, 0)));
      step();
    end

    idle();
    apply_reset();

    // 5: hold a RAW on $7 with no WB until the watchdog trips.
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    stalls_seen = 0;
    fault_seen = 1'b0;
    for (int i = 0; i < 40 && !fault_seen; i++) begin
      drive(1, 7, 0, 1, 0, 0, 0, 0, 0, 0); step();
      if (obs_fault) fault_seen = 1'b1;
      else if (obs_stall) stalls_seen++;
    end
    check("t5_fault_seen", 32'(fault_seen), 1);
    check("t5_stall_cycles", 32'(stalls_seen), 32'(MaxStall + 1));
    drive(1, 1, 2, 1, 1, 8, 1, 0, 0, 0); step();
    check("t5_issue_stuck", 32'(obs_issue), 0);
    drive(1, 7, 0, 1, 0, 0, 0, 1, 1, 7); step();
    check("t5_flush_in_fault", 32'(obs_flush), 1);
    idle(); step();
    check("t5_wb_drains", 32'(obs_busy), 0);
    check("t5_fault_sticky", 32'(obs_fault), 1);
    apply_reset();
    idle(); step();
    check("t5_fault_cleared", 32'(obs_fault), 0);

    // 6: reset in the middle of a stall with $9 pending.
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); step();
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0); step();
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0); step();
    check("t6_stalling", 32'(obs_stall), 1);
    apply_reset();
    idle(); step();
    check("t6_busy_cleared", 32'(obs_busy), 0);
    drive(1, 9, 0, 1, 0, 0, 0, 0, 0, 0); step();
    check("t6_issue_after_rst", 32'(obs_issue), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
